int_claim_arb: RTL and testbench

//  Interrupt gateway + priority arbiter of the platform interrupt controller; consumes the
//  per-source enable/priority/threshold values held in the controller's register file.

---
 rtl/int_pkg.sv | 14 +
 rtl/int_gateway.sv | 48 ++++
 rtl/int_claim_arb.sv | 114 +++++++++++
 tb/tb_int_claim_arb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt gateway / claim arbiter.
package int_pkg;

  localparam int NUM_SRC_DEF = 32;
  localparam int PRIO_W_DEF  = 3;
  localparam int ID_NONE     = 0;

  typedef enum logic [1:0] {
    GW_IDLE   = 2'd0,
    GW_PEND   = 2'd1,
    GW_INSERV = 2'd2
  } gw_state_e;

endpackage

// File: rtl/int_gateway.sv
// Per-source interrupt gateway: latches a level request as pending, moves to
// in-service on a successful claim, and returns to idle on completion.
module int_gateway
  import int_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic s,
  input  logic claim_hit,
  input  logic cmpl_hit,
  output logic pending
);

  gw_state_e state;
  gw_state_e state_nxt;

  // State register; pending mirrors the next state so it is a flop output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= GW_IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= (state_nxt == GW_PEND);
    end
  end

  // Next-state: level input is ignored while in service, so no re-trigger.
  always_comb begin
    state_nxt = state;
    case (state)
      GW_IDLE: begin
        if (s) state_nxt = GW_PEND;
        else   state_nxt = GW_IDLE;
      end
      GW_PEND: begin
        if (claim_hit) state_nxt = GW_INSERV;
        else           state_nxt = GW_PEND;
      end
      GW_INSERV: begin
        if (cmpl_hit) state_nxt = GW_IDLE;
        else          state_nxt = GW_INSERV;
      end
      default: state_nxt = GW_IDLE;
    endcase
  end

endmodule

// File: rtl/int_claim_arb.sv
// Interrupt gateway array plus priority arbiter with claim/complete handshake.
// Highest priority eligible source wins, ties go to the lowest ID. A claim
// forces a one-cycle bubble on the best_* registers so a back-to-back claim
// can never return the ID that was just handed out.
module int_claim_arb
  import int_pkg::*;
#(
  parameter  int NUM_SRC     = NUM_SRC_DEF,
  parameter  int PRIO_W      = PRIO_W_DEF,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_SRC-1:0]        irq_src,
  input  logic [NUM_SRC-1:0]        int_en,
  input  logic [NUM_SRC*PRIO_W-1:0] int_prio,
  input  logic [PRIO_W-1:0]         threshold,
  input  logic                      claim_req,
  output logic                      claim_vld,
  output logic [ID_W-1:0]           claim_id,
  input  logic                      cmpl_req,
  input  logic [ID_W-1:0]           cmpl_id,
  output logic [NUM_SRC-1:0]        pending,
  output logic                      irq_out
);

  logic [NUM_SRC-1:0] s_vec;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic [ID_W-1:0]    sel_id;
  logic [PRIO_W-1:0]  sel_prio;
  logic               claim_ok;

  // ID 0 is reserved, so its request, enable and priority bits are never consumed.
  logic unused_src0;
  assign unused_src0 = ^{s_vec[0], int_en[0], int_prio[PRIO_W-1:0]};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_vec = irq_src;
    end else begin : g_sync
      logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];

      // Synchronizer chain for asynchronous interrupt sources.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= {NUM_SRC{1'b0}};
        end else begin
          sync_q[0] <= irq_src;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign s_vec = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign claim_ok = (best_id != ID_W'(ID_NONE)) && (best_prio > threshold);

  assign pending[0] = 1'b0;

  generate
    for (genvar i = 1; i < NUM_SRC; i++) begin : g_gw
      int_gateway u_gw (
        .clk       (clk),
        .rstn      (rstn),
        .s         (s_vec[i]),
        .claim_hit (claim_req && claim_ok && (best_id == ID_W'(i))),
        .cmpl_hit  (cmpl_req && (cmpl_id == ID_W'(i))),
        .pending   (pending[i])
      );
    end
  endgenerate

  // Max-priority select; strict compare while scanning upward keeps the lowest ID on ties.
  always_comb begin
    sel_id   = {ID_W{1'b0}};
    sel_prio = {PRIO_W{1'b0}};
    for (int i = 1; i < NUM_SRC; i++) begin
      if (pending[i] && int_en[i] && (int_prio[i*PRIO_W +: PRIO_W] > sel_prio)) begin
        sel_id   = ID_W'(i);
        sel_prio = int_prio[i*PRIO_W +: PRIO_W];
      end else begin
        sel_id   = sel_id;
        sel_prio = sel_prio;
      end
    end
  end

  // Best-candidate, interrupt line and claim response registers (bubble on claim).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      best_id   <= {ID_W{1'b0}};
      best_prio <= {PRIO_W{1'b0}};
      irq_out   <= 1'b0;
      claim_vld <= 1'b0;
      claim_id  <= {ID_W{1'b0}};
    end else if (claim_req) begin
      best_id   <= {ID_W{1'b0}};
      best_prio <= {PRIO_W{1'b0}};
      irq_out   <= 1'b0;
      claim_vld <= 1'b1;
      claim_id  <= claim_ok ? best_id : {ID_W{1'b0}};
    end else begin
      best_id   <= sel_id;
      best_prio <= sel_prio;
      irq_out   <= (sel_id != ID_W'(ID_NONE)) && (sel_prio > threshold);
      claim_vld <= 1'b0;
      claim_id  <= {ID_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_int_claim_arb.sv
// Bench for int_claim_arb (32 sources, 3-bit priority, no synchronizer).
// Vector table for arbitration outcomes, then directed multi-cycle sequences.
module tb_int_claim_arb;

  logic        clk;
  logic        rstn;
  logic [31:0] irq_src;
  logic [31:0] int_en;
  logic [95:0] int_prio;
  logic [2:0]  threshold;
  logic        claim_req;
  logic        claim_vld;
  logic [4:0]  claim_id;
  logic        cmpl_req;
  logic [4:0]  cmpl_id;
  logic [31:0] pending;
  logic        irq_out;

  int total = 0;
  int bad   = 0;

  logic [4:0] sb[$];

  typedef struct {
    logic [31:0] src;
    logic [31:0] en;
    logic [95:0] prio;
    logic [2:0]  thr;
    logic [4:0]  exp_id;
    logic        exp_irq;
  } vec_t;

  vec_t vt[8];

  int_claim_arb #(
    .NUM_SRC     (32),
    .PRIO_W      (3),
    .SYNC_STAGES (0)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .irq_src   (irq_src),
    .int_en    (int_en),
    .int_prio  (int_prio),
    .threshold (threshold),
    .claim_req (claim_req),
    .claim_vld (claim_vld),
    .claim_id  (claim_id),
    .cmpl_req  (cmpl_req),
    .cmpl_id   (cmpl_id),
    .pending   (pending),
    .irq_out   (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [95:0] pr(input int id, input int p);
    logic [95:0] r;
    r = 96'd0;
    r[id*3 +: 3] = 3'(p);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    irq_src   = 32'd0;
    claim_req = 1'b0;
    cmpl_req  = 1'b0;
    cmpl_id   = 5'd0;
    #2;
    rstn = 1'b1;
  endtask

  task automatic do_claim(input logic [4:0] exp);
    logic [4:0] e;
    claim_req = 1'b1;
    sb.push_back(exp);
    step();
    claim_req = 1'b0;
    chk("claim_vld", 64'(claim_vld), 64'd1);
    e = sb.pop_front();
    chk("claim_id", 64'(claim_id), 64'(e));
  endtask

  task automatic do_cmpl(input logic [4:0] id);
    cmpl_req = 1'b1;
    cmpl_id  = id;
    step();
    cmpl_req = 1'b0;
    cmpl_id  = 5'd0;
  endtask

  initial begin
    rstn      = 1'b1;
    irq_src   = 32'd0;
    int_en    = 32'hFFFF_FFFF;
    int_prio  = 96'd0;
    threshold = 3'd0;
    claim_req = 1'b0;
    cmpl_req  = 1'b0;
    cmpl_id   = 5'd0;

    vt[0] = '{32'h0000_0020, 32'hFFFF_FFFF, pr(5,3),                      3'd0, 5'd5,  1'b1};
    vt[1] = '{32'h0000_0288, 32'hFFFF_FFFF, pr(3,2) | pr(7,6) | pr(9,6),  3'd0, 5'd7,  1'b1};
    vt[2] = '{32'h0000_0010, 32'hFFFF_FFFF, pr(4,2),                      3'd2, 5'd0,  1'b0};
    vt[3] = '{32'h0000_0400, 32'hFFFF_FBFF, pr(10,5),                     3'd0, 5'd0,  1'b0};
    vt[4] = '{32'h0000_1000, 32'hFFFF_FFFF, pr(12,0),                     3'd0, 5'd0,  1'b0};
    vt[5] = '{32'h8000_0002, 32'hFFFF_FFFF, pr(1,7) | pr(31,7),           3'd0, 5'd1,  1'b1};
    vt[6] = '{32'h0000_0001, 32'hFFFF_FFFF, pr(0,7),                      3'd0, 5'd0,  1'b0};
    vt[7] = '{32'h4000_0004, 32'hFFFF_FFFF, pr(2,1) | pr(30,4),           3'd3, 5'd30, 1'b1};

    // Reset state
    #3;
    do_reset();
    #1;
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_irq", 64'(irq_out), 64'd0);
    chk("rst_claim_vld", 64'(claim_vld), 64'd0);
    chk("rst_claim_id", 64'(claim_id), 64'd0);
    step();

    // Table-driven arbitration vectors
    for (int v = 0; v < 8; v++) begin
      do_reset();
      int_en    = vt[v].en;
      int_prio  = vt[v].prio;
      threshold = vt[v].thr;
      irq_src   = vt[v].src;
      step();
      irq_src = 32'd0;
      chk($sformatf("v%0d_pend", v), 64'(pending), 64'(vt[v].src & ~32'h1));
      chk($sformatf("v%0d_irq_early", v), 64'(irq_out), 64'd0);
      step();
      chk($sformatf("v%0d_irq", v), 64'(irq_out), 64'(vt[v].exp_irq));
      do_claim(vt[v].exp_id);
    end

    // Latency: pending one edge after source, irq_out one edge after that
    do_reset();
    int_en = 32'hFFFF_FFFF; int_prio = pr(5,3); threshold = 3'd0;
    irq_src = 32'h0000_0020;
    #1;
    chk("lat_pend_before", 64'(pending), 64'd0);
    step();
    chk("lat_pend", 64'(pending), 64'h20);
    chk("lat_irq_early", 64'(irq_out), 64'd0);
    step();
    chk("lat_irq", 64'(irq_out), 64'd1);
    chk("lat_no_vld", 64'(claim_vld), 64'd0);

    // Successive claims with idle cycles between them: 7, 9, 3, 0
    do_reset();
    int_prio = pr(3,2) | pr(7,6) | pr(9,6); threshold = 3'd0;
    irq_src = 32'h0000_0288;
    step();
    irq_src = 32'd0;
    step();
    do_claim(5'd7);
    chk("seq_bubble_irq", 64'(irq_out), 64'd0);
    chk("seq_pend", 64'(pending), 64'h208);
    step();
    do_claim(5'd9);
    step();
    do_claim(5'd3);
    step();
    do_claim(5'd0);
    chk("seq_irq_end", 64'(irq_out), 64'd0);

    // Threshold gating, then lowering threshold
    do_reset();
    int_prio = pr(4,2); threshold = 3'd2;
    irq_src = 32'h0000_0010;
    step();
    irq_src = 32'd0;
    step();
    chk("thr_irq0", 64'(irq_out), 64'd0);
    do_claim(5'd0);
    chk("thr_pend_kept", 64'(pending), 64'h10);
    threshold = 3'd1;
    step();
    chk("thr_irq1", 64'(irq_out), 64'd1);
    do_claim(5'd4);
    threshold = 3'd0;

    // No re-trigger while in service; re-pend after completion
    do_reset();
    int_prio = pr(6,3);
    irq_src = 32'h0000_0040;
    step();
    step();
    chk("ins_irq", 64'(irq_out), 64'd1);
    do_claim(5'd6);
    chk("ins_pend_clr", 64'(pending), 64'd0);
    repeat (3) step();
    chk("ins_no_repend", 64'(pending), 64'd0);
    chk("ins_irq_low", 64'(irq_out), 64'd0);
    do_cmpl(5'd6);
    chk("cmpl_idle", 64'(pending), 64'd0);
    step();
    chk("cmpl_repend", 64'(pending), 64'h40);
    step();
    chk("cmpl_irq", 64'(irq_out), 64'd1);

    // Back-to-back claims and ignored completes
    do_reset();
    int_prio = pr(11,2);
    irq_src = 32'h0000_0800;
    step();
    step();
    do_claim(5'd11);
    do_claim(5'd0);
    chk("b2b_pend", 64'(pending), 64'd0);
    do_cmpl(5'd0);
    step();
    chk("cmpl0_ignored", 64'(pending), 64'd0);
    do_cmpl(5'd20);
    step();
    chk("cmpl_idle_ignored", 64'(pending), 64'd0);
    do_cmpl(5'd11);
    step();
    chk("cmpl11_repend", 64'(pending), 64'h800);
    irq_src = 32'd0;

    // Asynchronous reset mid-service
    do_reset();
    int_prio = pr(2,5) | pr(8,1);
    irq_src = 32'h0000_0104;
    step();
    irq_src = 32'd0;
    step();
    do_claim(5'd2);
    step();
    chk("mid_irq", 64'(irq_out), 64'd1);
    chk("mid_pend", 64'(pending), 64'h100);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_irq", 64'(irq_out), 64'd0);
    chk("arst_pend", 64'(pending), 64'd0);
    chk("arst_vld", 64'(claim_vld), 64'd0);
    #1;
    rstn = 1'b1;
    step();
    chk("arst_pend_after", 64'(pending), 64'd0);
    irq_src = 32'h0000_0004;
    step();
    chk("arst_src2_idle", 64'(pending), 64'h4);
    step();
    chk("arst_irq_again", 64'(irq_out), 64'd1);
    irq_src = 32'd0;

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
